// File: rtl/rx_cmd_sequencer.sv
// Purpose: parse UART RX command frames into register-file writes/reads and ALU operations, returning results to the TX FIFO.
// Latency: strobes (WrEn/RdEn/ALU_EN) follow the accepted byte by one cycle; response bytes start one cycle after RdData_Valid/OUT_Valid.
// Backpressure: response bytes stall on FIFO_FULL indefinitely; RX bytes arriving while a response is pending are dropped.
module rx_cmd_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic                      Parity_Error,
    input  logic                      Stop_Error,
    input  logic [DATA_WIDTH-1:0]     RdData,
    input  logic                      RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_Valid,
    input  logic                      FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]     Address,
    output logic                      WrEn,
    output logic                      RdEn,
    output logic [DATA_WIDTH-1:0]     WrData,
    output logic                      ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
    output logic                      CLK_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic                      Frame_Error,
    output logic                      Busy
);

    localparam logic [DATA_WIDTH-1:0] CMD_WRITE   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_SEND_LO,
        ST_SEND_HI
    } state_t;

    state_t                     state;
    logic [2*DATA_WIDTH-1:0]    resp;
    logic                       two_byte;
    logic [TIMEOUT_WIDTH-1:0]   tmo_cnt;
    logic                       rx_err;
    logic                       timed;
    logic                       tmo_hit;

    assign rx_err  = Parity_Error | Stop_Error;
    // IDLE and the SEND states are exempt from both error abort and timeout
    assign timed   = !(state inside {ST_IDLE, ST_SEND_LO, ST_SEND_HI});
    assign tmo_hit = (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            resp        <= '0;
            two_byte    <= 1'b0;
            tmo_cnt     <= '0;
            Address     <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_EN      <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            Frame_Error <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            ALU_EN      <= 1'b0;
            TX_D_VLD    <= 1'b0;
            Frame_Error <= 1'b0;
            tmo_cnt     <= timed ? tmo_cnt + 1'b1 : '0;

            if (timed && (rx_err || tmo_hit)) begin
                state       <= ST_IDLE;
                Frame_Error <= 1'b1;
                Busy        <= 1'b0;
                CLK_EN      <= 1'b0;
                tmo_cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (RX_D_VLD) begin
                            tmo_cnt <= '0;
                            case (RX_P_DATA)
                                CMD_WRITE:   begin state <= ST_WR_ADDR; Busy <= 1'b1; end
                                CMD_READ:    begin state <= ST_RD_ADDR; Busy <= 1'b1; end
                                CMD_ALU_OP:  begin state <= ST_ALU_A;   Busy <= 1'b1; end
                                CMD_ALU_NOP: begin
                                    state  <= ST_ALU_FUN;
                                    Busy   <= 1'b1;
                                    CLK_EN <= 1'b1;
                                end
                                default:     Frame_Error <= 1'b1;
                            endcase
                        end
                    end
                    ST_WR_ADDR: begin
                        if (RX_D_VLD) begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state   <= ST_WR_DATA;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_WR_DATA: begin
                        if (RX_D_VLD) begin
                            WrEn    <= 1'b1;
                            WrData  <= RX_P_DATA;
                            state   <= ST_IDLE;
                            Busy    <= 1'b0;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (RX_D_VLD) begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            RdEn    <= 1'b1;
                            state   <= ST_RD_WAIT;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (RdData_Valid) begin
                            resp     <= {{DATA_WIDTH{1'b0}}, RdData};
                            two_byte <= 1'b0;
                            state    <= ST_SEND_LO;
                            tmo_cnt  <= '0;
                        end
                    end
                    // operands land in registers 0 and 1, where the ALU reads them
                    ST_ALU_A: begin
                        if (RX_D_VLD) begin
                            WrEn    <= 1'b1;
                            Address <= '0;
                            WrData  <= RX_P_DATA;
                            state   <= ST_ALU_B;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_ALU_B: begin
                        if (RX_D_VLD) begin
                            WrEn    <= 1'b1;
                            Address <= ADDR_WIDTH'(1);
                            WrData  <= RX_P_DATA;
                            state   <= ST_ALU_FUN;
                            CLK_EN  <= 1'b1;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_ALU_FUN: begin
                        if (RX_D_VLD) begin
                            ALU_EN  <= 1'b1;
                            ALU_FUN <= RX_P_DATA[ALU_FUN_WIDTH-1:0];
                            state   <= ST_ALU_WAIT;
                            tmo_cnt <= '0;
                        end
                    end
                    ST_ALU_WAIT: begin
                        if (OUT_Valid) begin
                            resp     <= ALU_OUT;
                            two_byte <= 1'b1;
                            state    <= ST_SEND_LO;
                            CLK_EN   <= 1'b0;
                            tmo_cnt  <= '0;
                        end
                    end
                    ST_SEND_LO: begin
                        if (!FIFO_FULL) begin
                            TX_D_VLD  <= 1'b1;
                            TX_P_DATA <= resp[DATA_WIDTH-1:0];
                            if (two_byte) begin
                                state <= ST_SEND_HI;
                            end else begin
                                state <= ST_IDLE;
                                Busy  <= 1'b0;
                            end
                        end
                    end
                    ST_SEND_HI: begin
                        if (!FIFO_FULL) begin
                            TX_D_VLD  <= 1'b1;
                            TX_P_DATA <= resp[2*DATA_WIDTH-1:DATA_WIDTH];
                            state     <= ST_IDLE;
                            Busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        Busy   <= 1'b0;
                        CLK_EN <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rx_cmd_sequencer.md
Name: rx_cmd_sequencer

Overview:
Command-level controller that sits behind the UART receive path. It consumes validated RX bytes plus the RX error flags, parses multi-byte command frames, and sequences register-file writes and reads and ALU operations. It returns read data and ALU results as bytes to the TX FIFO write port. It is the only master of the register file and ALU command interface on the RX side.

Parameters:
DATA_WIDTH, 8, width of the RX byte, register data, TX byte and each ALU result half.
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte.
ALU_FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte.
TIMEOUT, 255, number of idle cycles after which a partially received or stalled frame is aborted.
TIMEOUT_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TIMEOUT_WIDTH.

Ports:
CLK  in  1  system clock.
RST  in  1  asynchronous active-low reset.
RX_P_DATA  in  DATA_WIDTH  received byte; valid only when RX_D_VLD=1.
RX_D_VLD  in  1  one-cycle strobe that a good byte is present; already synchronised to CLK.
Parity_Error  in  1  RX parity error flag, level.
Stop_Error  in  1  RX stop error flag, level.
RdData  in  DATA_WIDTH  register-file read data.
RdData_Valid  in  1  read data valid strobe.
ALU_OUT  in  2*DATA_WIDTH  ALU result.
OUT_Valid  in  1  ALU result valid strobe.
FIFO_FULL  in  1  TX FIFO full.
Address  out  ADDR_WIDTH  register-file address.
WrEn  out  1  register write strobe, one cycle.
RdEn  out  1  register read strobe, one cycle.
WrData  out  DATA_WIDTH  register write data.
ALU_EN  out  1  ALU start strobe, one cycle.
ALU_FUN  out  ALU_FUN_WIDTH  ALU function code.
CLK_EN  out  1  ALU clock-gate enable.
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO.
TX_D_VLD  out  1  TX FIFO write strobe, one cycle.
Frame_Error  out  1  one-cycle pulse on frame abort.
Busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs registered. Reset value of every output is 0, and the state is IDLE. Reset mid-frame discards the frame, with no partial WrEn, RdEn or ALU_EN.
- Command bytes in IDLE:
  - 0xAA WRITE: addr, data.
  - 0xBB READ: addr.
  - 0xCC ALU_OP: A, B, fun.
  - 0xDD ALU_NOP: fun.
  - Any other byte: stay in IDLE and pulse Frame_Error.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI.
- WR_ADDR: on byte, latch Address -> WR_DATA.
- WR_DATA: on byte, next cycle WrEn=1 with Address and WrData=byte -> IDLE.
- RD_ADDR: on byte, next cycle RdEn=1 with Address -> RD_WAIT.
- RD_WAIT: on RdData_Valid, capture RdData, one-byte response -> SEND_LO.
- ALU_A: on byte, WrEn to Address 0 -> ALU_B.
- ALU_B: on byte, WrEn to Address 1 -> ALU_FUN.
- ALU_FUN: on byte, next cycle ALU_EN=1 and ALU_FUN=byte[ALU_FUN_WIDTH-1:0] -> ALU_WAIT.
- ALU_WAIT: on OUT_Valid, capture ALU_OUT, two-byte response -> SEND_LO.
- CLK_EN=1 in ALU_FUN, in ALU_WAIT, and during the ALU_EN cycle; 0 otherwise.
- SEND_LO: when FIFO_FULL=0, TX_D_VLD=1 with the low byte. Go to SEND_HI for a two-byte response, else IDLE.
- SEND_HI: when FIFO_FULL=0, TX_D_VLD=1 with the high byte -> IDLE.
- SEND states wait on FIFO_FULL indefinitely; no timeout applies.
- Errors: Parity_Error or Stop_Error high in any state other than IDLE, SEND_LO or SEND_HI -> IDLE and pulse Frame_Error.
  - Error and RX_D_VLD in the same cycle: the error wins and the byte is discarded.
  - Errors are ignored in IDLE.
- Timeout: the counter runs in every state except IDLE, SEND_LO and SEND_HI.
  - Cleared on state entry and on each accepted byte.
  - Reaching TIMEOUT -> IDLE and pulse Frame_Error.
- RX_D_VLD during RD_WAIT, ALU_WAIT, SEND_LO or SEND_HI: byte ignored, no error.
- Address, WrData and ALU_FUN hold their last value between strobes.

Test Plan:
- WRITE: bytes AA, 05, 3C -> one cycle of WrEn=1, Address=5, WrData=0x3C; Busy returns to 0.
- READ: bytes BB, 07; RdData=0x9E with RdData_Valid; FIFO_FULL=0 -> RdEn pulse with Address=7, then TX_P_DATA=0x9E with TX_D_VLD=1, exactly one TX_D_VLD pulse.
- ALU_OP: bytes CC, 0A, 03, 02; ALU_OUT=0x001E -> WrEn at Address 0 with 0x0A, WrEn at Address 1 with 0x03, ALU_EN with ALU_FUN=2, CLK_EN high; TX bytes 0x1E then 0x00.
- FIFO backpressure: in ALU_NOP (DD, 01) with ALU_OUT=0x1234, hold FIFO_FULL=1 for 20 cycles -> no TX_D_VLD; after release, 0x34 then 0x12 on consecutive available cycles.
- Error abort: AA, 02, then Stop_Error=1 together with the data byte -> no WrEn, Frame_Error pulse, IDLE. An unknown command byte 0x55 -> Frame_Error pulse.
- Timeout and reset: BB then no byte for TIMEOUT cycles -> Frame_Error pulse and IDLE. Asserting RST in ALU_B clears all outputs, with no WrEn or ALU_EN afterwards.
